// File: rtl/tt_pwm_pkg.sv
// Shared constants for the multi-channel PWM TinyTapeout design:
// channel limit and the pad-bus bit positions of each function.
package tt_pwm_pkg;

  // Upper bound on channels: io_o[7:6] are reserved for status.
  localparam int CHANNELS_MAX = 6;

  // Input pad bit positions.
  localparam int CLK_BIT    = 0;
  localparam int RST_BIT    = 1;
  localparam int SDATA_BIT  = 2;
  localparam int SSHIFT_BIT = 3;
  localparam int SLATCH_BIT = 4;

  // Output pad bit positions for status.
  localparam int PEND_BIT   = 6;
  localparam int STRB_BIT   = 7;

endpackage

// File: rtl/tt_pwm_timebase.sv
// PWM timebase: prescaler, period counter and (optionally) a direction flop.
// Build option: define PWM_CENTER_EN for center-aligned up/down counting
// (0..max..1 repeating); otherwise a plain wrapping up-counter is built.
// boundary marks the tick on which the counter leaves the last period value.
module tt_pwm_timebase #(
  parameter int DUTY_W    = 6,
  parameter int PRESC_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DUTY_W-1:0] cnt,
  output logic              boundary
);

  // A divide-by-1 prescaler still gets one bit so the code stays uniform;
  // it then sits at zero and ticks every cycle.
  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(PRESC_DIV - 1);
  localparam logic [DUTY_W-1:0] CNT_MAX    = '1;

  logic [PW-1:0]     presc_q, presc_d;
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic              tick;

`ifdef PWM_CENTER_EN
  localparam logic [DUTY_W-1:0] CNT_ONE = DUTY_W'(1);
  logic down_q, down_d;

  // Center-aligned: count up to max, then down to 1; period ends when 1 -> 0.
  always_comb begin
    tick     = (presc_q == PRESC_LAST);
    presc_d  = tick ? '0 : presc_q + 1'b1;
    cnt_d    = cnt_q;
    down_d   = down_q;
    boundary = tick && down_q && (cnt_q == CNT_ONE);
    if (tick) begin
      if (down_q) begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_ONE) down_d = 1'b0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d  = cnt_q - 1'b1;
        down_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Timebase registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
      down_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      down_q  <= down_d;
    end
  end
`else
  // Edge-aligned: free-running up-counter, natural wrap at max -> 0.
  always_comb begin
    tick     = (presc_q == PRESC_LAST);
    presc_d  = tick ? '0 : presc_q + 1'b1;
    cnt_d    = tick ? cnt_q + 1'b1 : cnt_q;
    boundary = tick && (cnt_q == CNT_MAX);
  end

  // Timebase registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end
`endif

  assign cnt = cnt_q;

endmodule

// File: rtl/tt_pwm_multi.sv
// Multi-channel PWM generator on the TinyTapeout 8-in/8-out pad bus.
// Duties arrive over a 3-wire serial link, are staged, and are applied
// only at a PWM period boundary so outputs never glitch mid-period.
// Build option: PWM_CENTER_EN selects center-aligned counting in the timebase.
//
// Serial load protocol (edge-qualified, no handshake back to the host):
//   - each rising edge of sshift shifts sdata into the LSB of the shift
//     register, MSB first; channel CHANNELS-1 ends up in the top DUTY_W bits;
//   - a rising edge of slatch copies the shift register into the stage and
//     raises pending; pending drops when the stage is applied at a boundary.
//   A level held high acts only once. If shift and latch edges coincide the
//   stage receives the pre-shift contents.
module tt_pwm_multi
  import tt_pwm_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int DUTY_W    = 6,
  parameter int PRESC_DIV = 1
) (
  input  logic [7:0] io_i,
  output logic [7:0] io_o
);

  localparam int N = CHANNELS * DUTY_W;

  logic clk, rst, sdata, sshift, slatch;
  assign clk    = io_i[CLK_BIT];
  assign rst    = io_i[RST_BIT];
  assign sdata  = io_i[SDATA_BIT];
  assign sshift = io_i[SSHIFT_BIT];
  assign slatch = io_i[SLATCH_BIT];

  // io_i[7:5] carry no function.
  logic unused_io;
  assign unused_io = &{1'b0, io_i[7:5]};

  logic [DUTY_W-1:0] cnt;
  logic              boundary;

  tt_pwm_timebase #(
    .DUTY_W   (DUTY_W),
    .PRESC_DIV(PRESC_DIV)
  ) u_timebase (
    .clk     (clk),
    .rst     (rst),
    .cnt     (cnt),
    .boundary(boundary)
  );

  logic          sshift_prev_q, sshift_prev_d;
  logic          slatch_prev_q, slatch_prev_d;
  logic [N-1:0]  sreg_q, sreg_d;
  logic [N-1:0]  stage_q, stage_d;
  logic [N-1:0]  duty_q, duty_d;
  logic          pending_q, pending_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic          strobe_q, strobe_d;
  logic          shift_edge, latch_edge;

  // Serial capture, staging and boundary apply of duty values.
  always_comb begin
    shift_edge    = sshift & ~sshift_prev_q;
    latch_edge    = slatch & ~slatch_prev_q;
    sshift_prev_d = sshift;
    slatch_prev_d = slatch;
    sreg_d        = sreg_q;
    stage_d       = stage_q;
    duty_d        = duty_q;
    pending_d     = pending_q;
    strobe_d      = boundary;
    // Apply first so a latch in the same cycle re-arms pending for the next period.
    if (boundary && pending_q) begin
      duty_d    = stage_q;
      pending_d = 1'b0;
    end
    if (latch_edge) begin
      stage_d   = sreg_q;
      pending_d = 1'b1;
    end
    if (shift_edge) begin
      sreg_d = {sreg_q[N-2:0], sdata};
    end
  end

  // Per-channel compare against the shared counter.
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = (cnt < duty_q[i*DUTY_W +: DUTY_W]);
    end
  end

  // All design state, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sshift_prev_q <= 1'b0;
      slatch_prev_q <= 1'b0;
      sreg_q        <= '0;
      stage_q       <= '0;
      duty_q        <= '0;
      pending_q     <= 1'b0;
      pwm_q         <= '0;
      strobe_q      <= 1'b0;
    end else begin
      sshift_prev_q <= sshift_prev_d;
      slatch_prev_q <= slatch_prev_d;
      sreg_q        <= sreg_d;
      stage_q       <= stage_d;
      duty_q        <= duty_d;
      pending_q     <= pending_d;
      pwm_q         <= pwm_d;
      strobe_q      <= strobe_d;
    end
  end

  // Pad mapping: PWM channels low, unused pads zero, status on top.
  always_comb begin
    io_o                 = '0;
    io_o[CHANNELS-1:0]   = pwm_q;
    io_o[PEND_BIT]       = pending_q;
    io_o[STRB_BIT]       = strobe_q;
  end

endmodule
